// File: rtl/l0_pkg.sv
// Shared types and helpers for the level-0 anchor bounding-box scan.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package l0_pkg;

    localparam int L0_DEPTH  = 16;
    localparam int L0_ADDR_W = 4;
    localparam int L0_DATA_W = 48;

    typedef logic [15:0] fp16_t;

    // SRAM word layout: x in [47:32], y in [31:16], z in [15:0].
    typedef struct packed {
        fp16_t x;
        fp16_t y;
        fp16_t z;
    } l0_word_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        FIN,
        DONE
    } state_t;

    // Sign-magnitude total order; +0 and -0 are equal, exp=31 codes are
    // ordered purely by their bit pattern.
    function automatic logic fp16_less(input fp16_t a, input fp16_t b);
        logic res;
        if ((a[14:0] == 15'd0) && (b[14:0] == 15'd0))
            res = 1'b0;
        else if (a[15] != b[15])
            res = a[15];
        else if (!a[15])
            res = (a[14:0] < b[14:0]);
        else
            res = (a[14:0] > b[14:0]);
        return res;
    endfunction

    // fp16 -> sign-magnitude fixed point scaled by 64 (shift by exp-19),
    // magnitude saturated to 0x7fff. Subnormals fall below one LSB.
    function automatic logic [15:0] fp16_to_fix(input fp16_t a);
        logic [4:0]  e;
        logic [31:0] man;
        logic [31:0] v;
        logic [14:0] mag;
        e   = a[14:10];
        man = {21'd0, 1'b1, a[9:0]};
        v   = 32'd0;
        mag = 15'd0;
        if (e == 5'd0) begin
            mag = 15'd0;
        end else if (e == 5'd31) begin
            mag = 15'h7fff;
        end else begin
            if (e < 5'd19)
                v = man >> (5'd19 - e);
            else
                v = man << (e - 5'd19);
            mag = (v > 32'h0000_7fff) ? 15'h7fff : v[14:0];
        end
        return {a[15], mag};
    endfunction

    // Sign-magnitude fixed point -> 20-bit two's complement.
    function automatic logic [19:0] sm_to_tc(input logic [15:0] s);
        logic [19:0] mag;
        mag = {5'd0, s[14:0]};
        return s[15] ? (20'd0 - mag) : mag;
    endfunction

endpackage

// File: rtl/level0_bbox_scan_minmax.sv
// fp16_minmax_axis: registered running min/max of one fp16 axis.
// Latency: 1 cycle from i_load/i_upd to o_min/o_max; ports: clk, rstn,
// i_clr/i_load/i_upd controls, i_val sample, o_min/o_max results.
// Backpressure: none, one sample per cycle; equality keeps the held value.
module fp16_minmax_axis
    import l0_pkg::*;
(
    input  logic  clk,
    input  logic  rstn,
    input  logic  i_clr,
    input  logic  i_load,
    input  logic  i_upd,
    input  fp16_t i_val,
    output fp16_t o_min,
    output fp16_t o_max
);

    fp16_t r_min;
    fp16_t r_max;

    always_ff @(posedge clk) begin
        if (!rstn || i_clr) begin
            r_min <= '0;
            r_max <= '0;
        end else if (i_load) begin
            r_min <= i_val;
            r_max <= i_val;
        end else if (i_upd) begin
            if (fp16_less(i_val, r_min))
                r_min <= i_val;
            if (fp16_less(r_max, i_val))
                r_max <= i_val;
        end
    end

    assign o_min = r_min;
    assign o_max = r_max;

endmodule

// File: rtl/level0_bbox_scan.sv
// level0_bbox_scan: reads back N=min(anchor_count,16) level-0 anchors and
// reports their per-axis fp16 bounding box. Latency: done at cycle N+2 after
// start (1 when N=0). Backpressure: none; start is ignored while busy.
// Ports: clk/rstn (sync, active-low), start/anchor_count in, SRAM read
// master (l0_cen_n, l0_wen, l0_addr, l0_data_out), busy/done/empty status,
// min_*/max_* results. Optional L0_CENTROID_SUM_EN adds sum_x/y/z
// (20-bit two's complement coordinate sums) and delays done by one cycle.
module level0_bbox_scan
    import l0_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [CNT_W-1:0]     anchor_count,
    output logic                 l0_cen_n,
    output logic                 l0_wen,
    output logic [L0_ADDR_W-1:0] l0_addr,
    input  logic [L0_DATA_W-1:0] l0_data_out,
    output logic                 busy,
    output logic                 done,
    output logic                 empty,
    output logic [15:0]          min_x,
    output logic [15:0]          min_y,
    output logic [15:0]          min_z,
    output logic [15:0]          max_x,
    output logic [15:0]          max_y,
    output logic [15:0]          max_z
`ifdef L0_CENTROID_SUM_EN
   ,output logic [19:0]          sum_x,
    output logic [19:0]          sum_y,
    output logic [19:0]          sum_z
`endif
);

`ifdef L0_CENTROID_SUM_EN
    // The conversion stage adds one cycle after the last read word.
    localparam logic DRAIN_SINGLE = 1'b0;
`else
    localparam logic DRAIN_SINGLE = 1'b1;
`endif

    state_t                r_state;
    logic                  r_cen_n;
    logic [L0_ADDR_W-1:0]  r_addr;
    logic [4:0]            r_n;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_empty;
    logic                  r_drain_last;
    logic                  r_rd_vld;
    logic                  r_first;

    logic                  w_accept;
    logic [4:0]            w_n_eff;
    logic                  w_load;
    logic                  w_upd;
    l0_word_t              w_word;

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_n_eff  = (anchor_count >= CNT_W'(L0_DEPTH)) ? 5'(L0_DEPTH)
                                                         : anchor_count[4:0];
    assign w_word   = l0_word_t'(l0_data_out);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_cen_n      <= 1'b1;
            r_addr       <= '0;
            r_n          <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_empty      <= 1'b0;
            r_drain_last <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_n     <= w_n_eff;
                        r_busy  <= 1'b1;
                        r_empty <= (w_n_eff == 5'd0);
                        if (w_n_eff != 5'd0) begin
                            r_state <= FETCH;
                            r_cen_n <= 1'b0;
                            r_addr  <= '0;
                        end else begin
`ifdef L0_CENTROID_SUM_EN
                            r_state      <= DRAIN;
                            r_drain_last <= 1'b1;
`else
                            r_state <= FIN;
                            r_done  <= 1'b1;
`endif
                        end
                    end
                end
                FETCH: begin
                    if ({1'b0, r_addr} == (r_n - 5'd1)) begin
                        r_state      <= DRAIN;
                        r_cen_n      <= 1'b1;
                        r_drain_last <= DRAIN_SINGLE;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (r_drain_last) begin
                        r_state <= FIN;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain_last <= 1'b1;
                    end
                end
                FIN: begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Read data is qualified by a one-cycle delayed copy of the chip enable;
    // r_first picks the word that seeds min=max.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rd_vld <= 1'b0;
            r_first  <= 1'b0;
        end else begin
            r_rd_vld <= ~r_cen_n;
            if (w_accept)
                r_first <= 1'b1;
            else if (r_rd_vld)
                r_first <= 1'b0;
        end
    end

    assign w_load = r_rd_vld & r_first;
    assign w_upd  = r_rd_vld & ~r_first;

    fp16_minmax_axis u_axis_x (
        .clk(clk), .rstn(rstn), .i_clr(w_accept), .i_load(w_load),
        .i_upd(w_upd), .i_val(w_word.x), .o_min(min_x), .o_max(max_x)
    );
    fp16_minmax_axis u_axis_y (
        .clk(clk), .rstn(rstn), .i_clr(w_accept), .i_load(w_load),
        .i_upd(w_upd), .i_val(w_word.y), .o_min(min_y), .o_max(max_y)
    );
    fp16_minmax_axis u_axis_z (
        .clk(clk), .rstn(rstn), .i_clr(w_accept), .i_load(w_load),
        .i_upd(w_upd), .i_val(w_word.z), .o_min(min_z), .o_max(max_z)
    );

`ifdef L0_CENTROID_SUM_EN
    logic        r_conv_vld;
    logic [15:0] r_cx;
    logic [15:0] r_cy;
    logic [15:0] r_cz;
    logic [19:0] r_sum_x;
    logic [19:0] r_sum_y;
    logic [19:0] r_sum_z;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_conv_vld <= 1'b0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_cz       <= '0;
            r_sum_x    <= '0;
            r_sum_y    <= '0;
            r_sum_z    <= '0;
        end else begin
            r_conv_vld <= r_rd_vld;
            if (r_rd_vld) begin
                r_cx <= fp16_to_fix(w_word.x);
                r_cy <= fp16_to_fix(w_word.y);
                r_cz <= fp16_to_fix(w_word.z);
            end
            if (w_accept) begin
                r_sum_x <= '0;
                r_sum_y <= '0;
                r_sum_z <= '0;
            end else if (r_conv_vld) begin
                r_sum_x <= r_sum_x + sm_to_tc(r_cx);
                r_sum_y <= r_sum_y + sm_to_tc(r_cy);
                r_sum_z <= r_sum_z + sm_to_tc(r_cz);
            end
        end
    end

    assign sum_x = r_sum_x;
    assign sum_y = r_sum_y;
    assign sum_z = r_sum_z;
`endif

    assign l0_cen_n = r_cen_n;
    assign l0_wen   = 1'b0;
    assign l0_addr  = r_addr;
    assign busy     = r_busy;
    assign done     = r_done;
    assign empty    = r_empty;

endmodule

// File: tb/tb_level0_bbox_scan.sv
// Bench for level0_bbox_scan: directed table, corner sequences, random scans.
// Latency: checks done at N+2 (N+3 with L0_CENTROID_SUM_EN).
// Backpressure: n/a; a behavioural SRAM answers one cycle after each read.
module tb_level0_bbox_scan;

`ifdef L0_CENTROID_SUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [31:0] anchor_count;
    logic        l0_cen_n;
    logic        l0_wen;
    logic [3:0]  l0_addr;
    logic [47:0] l0_data_out;
    logic        busy, done, empty;
    logic [15:0] min_x, min_y, min_z, max_x, max_y, max_z;
`ifdef L0_CENTROID_SUM_EN
    logic [19:0] sum_x, sum_y, sum_z;
`endif

    logic [47:0] mem [16];
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    level0_bbox_scan dut (
        .clk(clk), .rstn(rstn), .start(start), .anchor_count(anchor_count),
        .l0_cen_n(l0_cen_n), .l0_wen(l0_wen), .l0_addr(l0_addr),
        .l0_data_out(l0_data_out), .busy(busy), .done(done), .empty(empty),
        .min_x(min_x), .min_y(min_y), .min_z(min_z),
        .max_x(max_x), .max_y(max_y), .max_z(max_z)
`ifdef L0_CENTROID_SUM_EN
       ,.sum_x(sum_x), .sum_y(sum_y), .sum_z(sum_z)
`endif
    );

    // Synchronous-read SRAM: data appears the cycle after the address.
    always @(posedge clk) begin
        if (!l0_cen_n)
            l0_data_out <= mem[l0_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [95:0] dut_mm();
        return {min_x, max_x, min_y, max_y, min_z, max_z};
    endfunction

    function automatic int eff(input int cnt);
        return (cnt > 16) ? 16 : cnt;
    endfunction

    // Order key: signed integer whose numeric order equals the fp16 order.
    function automatic int key(input logic [15:0] a);
        int mag;
        mag = int'(a[14:0]);
        return a[15] ? -mag : mag;
    endfunction

    function automatic logic [95:0] model_mm(input int n);
        logic [15:0] mn [3];
        logic [15:0] mx [3];
        logic [15:0] v;
        for (int a = 0; a < 3; a++) begin
            mn[a] = 16'h0000;
            mx[a] = 16'h0000;
            for (int i = 0; i < n; i++) begin
                v = mem[i][47 - 16*a -: 16];
                if (i == 0) begin
                    mn[a] = v;
                    mx[a] = v;
                end else begin
                    if (key(v) < key(mn[a])) mn[a] = v;
                    if (key(v) > key(mx[a])) mx[a] = v;
                end
            end
        end
        return {mn[0], mx[0], mn[1], mx[1], mn[2], mx[2]};
    endfunction

    // Real-valued fp16 times 64, truncated and saturated, signed.
    function automatic int fix(input logic [15:0] a);
        int  e, m, mag;
        real v;
        e = int'(a[14:10]);
        m = int'(a[9:0]);
        if (e == 0) v = m * (2.0 ** (-18));
        else        v = (1024.0 + m) * (2.0 ** (e - 19));
        mag = (v >= 32767.0) ? 32767 : $rtoi(v);
        return a[15] ? -mag : mag;
    endfunction

    function automatic logic [59:0] model_sum(input int n);
        int s [3];
        logic [19:0] r [3];
        for (int a = 0; a < 3; a++) begin
            s[a] = 0;
            for (int i = 0; i < n; i++)
                s[a] += fix(mem[i][47 - 16*a -: 16]);
            r[a] = 20'(s[a]);
        end
        return {r[0], r[1], r[2]};
    endfunction

    task automatic do_scan(input string nm, input int cnt, input logic [95:0] exp_mm,
                           input logic exp_empty, input int exp_done);
        int cyc, dcyc, nrd, aerr, n;
        logic [95:0] held;
        n = eff(cnt);
        start = 1'b1;
        anchor_count = cnt;
        tick();
        start = 1'b0;
        chk({nm, "_busy1"}, {95'd0, busy}, 96'd1);
        chk({nm, "_clr_on_start"}, dut_mm(), 96'd0);
        cyc = 1; dcyc = 0; nrd = 0; aerr = 0;
        while (cyc < 60) begin
            if (!l0_cen_n) begin
                if (int'(l0_addr) != nrd) aerr++;
                nrd++;
            end
            if (done) begin
                dcyc = cyc;
                break;
            end
            tick();
            cyc++;
        end
        chk({nm, "_done_cycle"}, 96'(dcyc), 96'(exp_done));
        chk({nm, "_reads"}, 96'(nrd), 96'(n));
        chk({nm, "_addr_seq_errs"}, 96'(aerr), 96'd0);
        chk({nm, "_minmax"}, dut_mm(), exp_mm);
        chk({nm, "_empty"}, {95'd0, empty}, {95'd0, exp_empty});
        chk({nm, "_wen"}, {95'd0, l0_wen}, 96'd0);
`ifdef L0_CENTROID_SUM_EN
        chk({nm, "_sums"}, {36'd0, sum_x, sum_y, sum_z}, {36'd0, model_sum(n)});
`endif
        held = dut_mm();
        tick();
        chk({nm, "_post_done_busy"}, {94'd0, done, busy}, 96'd0);
        chk({nm, "_hold"}, dut_mm(), held);
    endtask

    typedef struct {
        int          cnt;
        logic [15:0] x0, x1, x2, x3, xf, x15, yz;
        logic [15:0] mnx, mxx, mny, mxy;
        logic        emp;
        int          dcyc;
    } vec_t;

    vec_t tv [7];

    initial begin
        int          dcyc, ndone, n;
        logic [15:0] r16 [3];

        tv[0] = '{3,  16'h3C00, 16'hBC00, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h3800,
                  16'hBC00, 16'h4000, 16'h3800, 16'h3800, 1'b0, 5};
        tv[1] = '{0,  16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3800,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1};
        tv[2] = '{40, 16'h3C00, 16'h4000, 16'h3800, 16'h0000, 16'h4400, 16'hC500, 16'h3800,
                  16'hC500, 16'h4400, 16'h3800, 16'h3800, 1'b0, 18};
        tv[3] = '{2,  16'h8000, 16'h0000, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'hBC00,
                  16'h8000, 16'h8000, 16'hBC00, 16'hBC00, 1'b0, 4};
        tv[4] = '{4,  16'h0001, 16'h8001, 16'h7C00, 16'hFC00, 16'h0000, 16'h0000, 16'h0000,
                  16'hFC00, 16'h7C00, 16'h0000, 16'h0000, 1'b0, 6};
        tv[5] = '{2,  16'h0000, 16'h8000, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00,
                  16'h0000, 16'h0000, 16'h3C00, 16'h3C00, 1'b0, 4};
        tv[6] = '{2,  16'h3C00, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h3800,
                  16'h3C00, 16'h4000, 16'h3800, 16'h3800, 1'b0, 4};

        for (int i = 0; i < 16; i++) mem[i] = '0;
        rstn = 1'b0;
        start = 1'b0;
        anchor_count = '0;
        repeat (3) tick();
        chk("reset_outputs", {dut_mm(), 3'b000}, 99'd0);
        chk("reset_status", {91'd0, l0_cen_n, l0_wen, busy, done, empty}, {91'd0, 5'b10000});
        rstn = 1'b1;
        tick();
        chk("idle_status", {92'd0, l0_cen_n, busy, done, empty}, {92'd0, 4'b1000});

        // Directed table.
        for (int t = 0; t < 7; t++) begin
            for (int i = 0; i < 16; i++) begin
                logic [15:0] xv;
                xv = (i == 0) ? tv[t].x0 : (i == 1) ? tv[t].x1 : (i == 2) ? tv[t].x2 :
                     (i == 3) ? tv[t].x3 : (i == 15) ? tv[t].x15 : tv[t].xf;
                mem[i] = {xv, tv[t].yz, tv[t].yz};
            end
            do_scan($sformatf("tv%0d", t), tv[t].cnt,
                    {tv[t].mnx, tv[t].mxx, tv[t].mny, tv[t].mxy, tv[t].mny, tv[t].mxy},
                    tv[t].emp, tv[t].dcyc + EXTRA);
`ifdef L0_CENTROID_SUM_EN
            if (t == 6) chk("tv6_sum_x_192", {76'd0, sum_x}, 96'd192);
`endif
        end

        // Second start during a scan is ignored.
        for (int i = 0; i < 16; i++)
            mem[i] = {16'($urandom), 16'($urandom), 16'($urandom)};
        start = 1'b1;
        anchor_count = 5;
        tick();
        ndone = 0; dcyc = 0;
        for (int c = 1; c <= 12; c++) begin
            start = (c == 3);
            anchor_count = (c == 3) ? 32'd2 : 32'd5;
            if (done) begin
                ndone++;
                dcyc = c;
            end
            tick();
        end
        start = 1'b0;
        chk("restart_ignored_ndone", 96'(ndone), 96'd1);
        chk("restart_ignored_dcyc", 96'(dcyc), 96'(7 + EXTRA));
        chk("restart_ignored_mm", dut_mm(), model_mm(5));

        // Reset in the middle of a scan.
        start = 1'b1;
        anchor_count = 5;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("midreset_outputs", {dut_mm(), 3'b000}, 99'd0);
        chk("midreset_status", {92'd0, l0_cen_n, busy, done, empty}, {92'd0, 4'b1000});
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            if (done) ndone++;
            tick();
        end
        chk("midreset_no_done", 96'(ndone), 96'd0);

        // Randomised scans against the reference model.
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < 16; i++) begin
                for (int a = 0; a < 3; a++) begin
                    case ($urandom_range(0, 3))
                        0:       r16[a] = 16'($urandom) & 16'h8000;
                        1:       r16[a] = 16'($urandom) | 16'h7C00;
                        default: r16[a] = 16'($urandom);
                    endcase
                end
                mem[i] = {r16[0], r16[1], r16[2]};
            end
            n = int'($urandom_range(0, 24));
            do_scan($sformatf("rnd%0d", r), n, model_mm(eff(n)), (n == 0),
                    (n == 0) ? (1 + EXTRA) : (eff(n) + 2 + EXTRA));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
